// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one block-RAM port among N valid/ready requesters.
// Registered RAM command, 2-cycle read return with per-requester rsp_valid.
module ram_rr_arbiter #(
  parameter int N         = 4,
  parameter int DEPTH     = 2048,
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [N-1:0]           req_valid,
  output logic [N-1:0]           req_ready,
  input  logic [N-1:0]           req_write,
  input  logic [N*ADDR_BITS-1:0] req_addr,
  input  logic [N*WIDTH-1:0]     req_wdata,
  output logic [N-1:0]           rsp_valid,
  output logic [WIDTH-1:0]       rsp_rdata,
  output logic [ADDR_BITS-1:0]   ram_address,
  output logic                   ram_wren,
  output logic [WIDTH-1:0]       ram_data,
  input  logic [WIDTH-1:0]       ram_q
);

  localparam int ID_BITS = (N > 1) ? $clog2(N) : 1;

  logic [ID_BITS-1:0] ptr;
  logic [ID_BITS-1:0] gnt_id;
  logic               gnt_any;
  logic [N-1:0]       gnt_onehot;
  logic               xfer;
  logic               s1_read;
  logic [ID_BITS-1:0] s1_id;
  logic [WIDTH-1:0]   rdata_last;

  // Scan downward so the lowest offset from ptr is the one that sticks.
  always_comb begin
    int                 idx;
    logic [ID_BITS-1:0] idx_b;
    gnt_any    = 1'b0;
    gnt_id     = '0;
    gnt_onehot = '0;
    idx        = 0;
    idx_b      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      idx_b = ID_BITS'(idx);
      if (req_valid[idx_b]) begin
        gnt_any = 1'b1;
        gnt_id  = idx_b;
      end
    end
    if (gnt_any && reset_n) gnt_onehot[gnt_id] = 1'b1;
  end

  assign req_ready = gnt_onehot;
  assign xfer      = |gnt_onehot;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr         <= '0;
      ram_address <= '0;
      ram_wren    <= 1'b0;
      ram_data    <= '0;
      s1_read     <= 1'b0;
      s1_id       <= '0;
      rsp_valid   <= '0;
      rdata_last  <= '0;
    end else begin
      ram_wren <= xfer & req_write[gnt_id];
      if (xfer) begin
        ram_address <= req_addr[gnt_id*ADDR_BITS +: ADDR_BITS];
        ram_data    <= req_wdata[gnt_id*WIDTH +: WIDTH];
        ptr         <= (gnt_id == ID_BITS'(N - 1)) ? '0 : gnt_id + 1'b1;
      end
      s1_read <= xfer & ~req_write[gnt_id];
      s1_id   <= gnt_id;
      rsp_valid <= '0;
      if (s1_read) rsp_valid[s1_id] <= 1'b1;
      if (|rsp_valid) rdata_last <= ram_q;
    end
  end

  // ram_q is already the RAM's output register; pass it through in the
  // response cycle and hold it afterwards so latency stays at two cycles.
  assign rsp_rdata = (|rsp_valid) ? ram_q : rdata_last;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter with a behavioural 1-cycle registered-read RAM.
module tb_ram_rr_arbiter;
  localparam int N     = 4;
  localparam int DEPTH = 2048;
  localparam int WIDTH = 8;
  localparam int AB    = 11;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req_valid, req_ready, req_write, rsp_valid;
  logic [N*AB-1:0]  req_addr;
  logic [N*WIDTH-1:0] req_wdata;
  logic [WIDTH-1:0] rsp_rdata, ram_data, ram_q;
  logic [AB-1:0]    ram_address;
  logic             ram_wren;

  logic [WIDTH-1:0] mem [DEPTH];
  bit               written [DEPTH] = '{default: 1'b0};

  int errors = 0;
  int checks = 0;
  int tally [N];

  always #5 clock = ~clock;

  ram_rr_arbiter #(.N(N), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data),
    .ram_q(ram_q)
  );

  function automatic logic [WIDTH-1:0] init_val(logic [AB-1:0] a);
    return a[7:0] ^ 8'h5A ^ {5'b0, a[10:8]};
  endfunction

  always @(posedge clock) begin
    if (ram_wren) begin
      mem[ram_address]     <= ram_data;
      written[ram_address] <= 1'b1;
    end
    ram_q <= written[ram_address] ? mem[ram_address] : init_val(ram_address);
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(int i, logic v, logic w, logic [AB-1:0] a, logic [WIDTH-1:0] d);
    req_valid[i] = v;
    req_write[i] = w;
    req_addr[i*AB +: AB] = a;
    req_wdata[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    step();
    step();
    @(negedge clock);
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) tally[i] = 0;

    // reset with all requesters pending
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 11'h000, 8'h00);
    step();
    step();
    @(negedge clock);
    check("rst_ready", req_ready, 4'b0000);
    check("rst_wren", ram_wren, 1'b0);
    check("rst_rsp_valid", rsp_valid, 4'b0000);
    check("rst_rdata", rsp_rdata, 8'h00);
    check("rst_addr", ram_address, 11'h000);
    reset_n = 1'b1;
    #1;
    check("first_grant", req_ready, 4'b0001);
    req_valid = '0;
    step();

    // single requester write then read-back
    set_req(2, 1'b1, 1'b1, 11'h005, 8'hA5);
    @(negedge clock);
    check("t2_ready_w", req_ready, 4'b0100);
    step();
    set_req(2, 1'b1, 1'b0, 11'h005, 8'h00);
    @(negedge clock);
    check("t2_ready_r", req_ready, 4'b0100);
    check("t2_wren", ram_wren, 1'b1);
    check("t2_addr", ram_address, 11'h005);
    check("t2_data", ram_data, 8'hA5);
    step();
    req_valid = '0;
    @(negedge clock);
    check("t2_wren_rd", ram_wren, 1'b0);
    check("t2_rsp_early", rsp_valid, 4'b0000);
    step();
    @(negedge clock);
    check("t2_rsp_valid", rsp_valid, 4'b0100);
    check("t2_rdata", rsp_rdata, 8'hA5);
    step();
    @(negedge clock);
    check("t2_rsp_clear", rsp_valid, 4'b0000);
    check("t2_rdata_hold", rsp_rdata, 8'hA5);

    // fairness under continuous demand
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 11'h100 + 11'(i), 8'h00);
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clock);
      check("t3_grant", req_ready, 4'b0001 << (cyc % 4));
      for (int i = 0; i < N; i++) tally[i] += int'(req_ready[i]);
      if (cyc >= 2) begin
        check("t3_rsp_valid", rsp_valid, 4'b0001 << ((cyc - 2) % 4));
        check("t3_rdata", rsp_rdata, init_val(11'h100 + 11'((cyc - 2) % 4)));
      end
      step();
    end
    req_valid = '0;
    for (int i = 0; i < N; i++) check("t3_tally", tally[i], 10);
    step();
    step();

    // pointer skip
    set_req(0, 1'b1, 1'b0, 11'h010, 8'h00);
    @(negedge clock);
    check("t4_g0", req_ready, 4'b0001);
    step();
    set_req(3, 1'b1, 1'b0, 11'h011, 8'h00);
    @(negedge clock);
    check("t4_skip_to3", req_ready, 4'b1000);
    step();
    @(negedge clock);
    check("t4_then0", req_ready, 4'b0001);
    step();
    set_req(1, 1'b1, 1'b0, 11'h012, 8'h00);
    @(negedge clock);
    check("t4_late1", req_ready, 4'b0010);
    step();
    @(negedge clock);
    check("t4_next3", req_ready, 4'b1000);
    step();
    @(negedge clock);
    check("t4_wrap0", req_ready, 4'b0001);
    step();
    req_valid = '0;
    step();
    step();

    // back-to-back write/read at the top address, then address 0
    set_req(0, 1'b1, 1'b1, 11'h7FF, 8'h3C);
    @(negedge clock);
    check("t5_ready_w", req_ready, 4'b0001);
    step();
    set_req(0, 1'b0, 1'b0, 11'h000, 8'h00);
    set_req(1, 1'b1, 1'b0, 11'h7FF, 8'h00);
    @(negedge clock);
    check("t5_ready_r", req_ready, 4'b0010);
    check("t5_wren", ram_wren, 1'b1);
    check("t5_addr", ram_address, 11'h7FF);
    check("t5_data", ram_data, 8'h3C);
    step();
    set_req(1, 1'b1, 1'b0, 11'h000, 8'h00);
    @(negedge clock);
    check("t5_ready_r0", req_ready, 4'b0010);
    step();
    req_valid = '0;
    @(negedge clock);
    check("t5_rsp_valid", rsp_valid, 4'b0010);
    check("t5_rdata_new", rsp_rdata, 8'h3C);
    check("t5_addr0", ram_address, 11'h000);
    step();
    @(negedge clock);
    check("t5_rsp_valid0", rsp_valid, 4'b0010);
    check("t5_rdata_noalias", rsp_rdata, 8'h5A);
    step();

    // reset with reads in flight
    set_req(2, 1'b1, 1'b0, 11'h100, 8'h00);
    @(negedge clock);
    check("t6_ready2", req_ready, 4'b0100);
    step();
    set_req(2, 1'b0, 1'b0, 11'h000, 8'h00);
    set_req(3, 1'b1, 1'b0, 11'h101, 8'h00);
    @(negedge clock);
    check("t6_ready3", req_ready, 4'b1000);
    reset_n = 1'b0;
    #1;
    check("t6_rst_ready", req_ready, 4'b0000);
    check("t6_rst_wren", ram_wren, 1'b0);
    check("t6_rst_addr", ram_address, 11'h000);
    check("t6_rst_rsp", rsp_valid, 4'b0000);
    req_valid = '0;
    for (int c = 0; c < 2; c++) begin
      step();
      @(negedge clock);
      check("t6_rsp_in_rst", rsp_valid, 4'b0000);
    end
    reset_n = 1'b1;
    step();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 11'h020 + 11'(i), 8'h00);
    set_req(0, 1'b1, 1'b0, 11'h005, 8'h00);
    @(negedge clock);
    check("t6_ptr0", req_ready, 4'b0001);
    check("t6_no_rsp_a", rsp_valid, 4'b0000);
    step();
    req_valid = '0;
    @(negedge clock);
    check("t6_no_rsp_b", rsp_valid, 4'b0000);
    step();
    @(negedge clock);
    check("t6_resume_valid", rsp_valid, 4'b0001);
    check("t6_resume_rdata", rsp_rdata, 8'hA5);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
- Shares one read/write port of the dual-port block RAM wrapper (DEPTH x WIDTH, 1-cycle registered read) between N requesters.
- Round-robin arbitration with a valid/ready handshake per requester.
- Command outputs to the RAM are registered, so timing closes independently of requester logic.
- Read data is broadcast on one bus; a per-requester rsp_valid qualifies it. Sits between CPU-side/DMA-side masters and port A or B of the RAM.

Parameters:
- N, 4, number of requesters (2..8)
- DEPTH, 2048, RAM words
- WIDTH, 8, data width in bits
- ADDR_BITS, $clog2(DEPTH), address width (derived; do not override)

Ports:
- clock  in  1  single clock; RAM port clock must be the same clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  N  request pending, one bit per requester
- req_ready  out  N  request accepted this cycle (one-hot or zero)
- req_write  in  N  1 = write, 0 = read, per requester
- req_addr  in  N*ADDR_BITS  address; requester i uses slice [i*ADDR_BITS +: ADDR_BITS]
- req_wdata  in  N*WIDTH  write data; requester i uses slice [i*WIDTH +: WIDTH]
- rsp_valid  out  N  rsp_rdata valid for requester i (one-hot or zero)
- rsp_rdata  out  WIDTH  read data, shared by all requesters
- ram_address  out  ADDR_BITS  to RAM address port
- ram_wren  out  1  to RAM write enable
- ram_data  out  WIDTH  to RAM write data
- ram_q  in  WIDTH  from RAM q; valid 1 cycle after ram_address is sampled

Behaviour:
- Reset (async assert, sync release):
  - ram_address=0, ram_wren=0, ram_data=0
  - rsp_valid=0, rsp_rdata=0
  - priority pointer=0
  - all in-flight tag pipeline stages cleared
- Arbitration:
  - Combinational; every cycle the grant goes to the first requester with req_valid=1, searching from ptr upward, modulo N.
  - req_ready[i]=1 only for the granted i. req_ready is 0 for all while reset_n=0.
  - Transfer occurs when req_valid[i] and req_ready[i] are both 1. Max one transfer per cycle; 100% port utilisation under continuous demand.
  - After a transfer by i, ptr <= (i+1) mod N. With no transfer, ptr holds.
  - A requester must hold valid/write/addr/wdata stable until ready. Dropping valid before ready is permitted; the request is then simply not issued.
- Command stage (cycle T+1, where T is the accept cycle):
  - ram_address/ram_data register the winner's addr/wdata; ram_wren <= write.
  - No transfer: ram_wren <= 0; address/data hold their previous values.
- Read return:
  - Tag pipeline carries {valid_read, id}: T -> T+1 (RAM samples) -> T+2.
  - At T+2: rsp_valid[id]=1 for one cycle; rsp_rdata = ram_q, registered at T+2 edge output per rsp_valid.
  - Read latency is exactly 2 cycles from accept to rsp_valid. Fixed, no backpressure; requesters must always accept responses.
  - rsp_rdata holds its last value when rsp_valid=0.
- Writes:
  - Complete at acceptance from the requester's view; no response.
  - A write accepted at T followed by a read of the same address accepted at T+1 returns the new data. RAM p1 ordering; the arbiter preserves acceptance order.
- Out-of-range address bits cannot occur: slices are exactly ADDR_BITS.
- Reset asserted mid-operation:
  - Pending commands are discarded; ram_wren drops immediately.
  - No rsp_valid is issued for reads accepted before reset.
- N=1 degenerates to a pass-through with a 2-cycle read latency; ptr stays 0.

Test Plan:
1. Reset, then idle: hold reset_n=0 with req_valid=4'b1111 -> req_ready=0, ram_wren=0, rsp_valid=0. Release -> first grant goes to requester 0.
2. Single requester: requester 2 writes addr 0x005 data 0xA5 at T, reads 0x005 at T+1 -> ram_wren=1 at T+1; rsp_valid=4'b0100 at T+3 with rsp_rdata=0xA5.
3. Fairness: all 4 valid continuously with reads -> grants cycle 0,1,2,3,0,... Over 40 cycles each requester gets exactly 10. rsp_valid follows the same order 2 cycles later.
4. Pointer skip: ptr=1 after a grant to 0; only requesters 0 and 3 valid -> grant 3, then 0. Requester 1 rises later -> served before 0 when ptr=1.
5. Back-to-back mixed: requester 1 reads 0x7FF while requester 0 writes 0x7FF in the previous cycle -> requester 1 sees the new data. Address 0x7FF (wrap boundary) handled with no aliasing to 0x000.
6. Reset mid-flight: accept reads at T and T+1, assert reset_n=0 at T+1.5 -> no rsp_valid ever for those reads. After release, ptr=0 and normal operation resumes.
